// File: rtl/wb_bus_if.sv
// wb_bus_if
// Bridges the core's single-cycle memory request port to a Wishbone B4
// classic master. One transfer is in flight at a time. The pipeline is held
// through stallreq_o until the slave acks or the timeout aborts the cycle.
// Read data is kept in rd_buf while the pipeline is stalled for other reasons.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst_n       synchronous reset, active high (1 = reset)
//   stall_i     pipeline stall vector from ctrl
//   flush_i     pipeline flush, abandons the current request
//   cpu_ce_i    core request valid
//   cpu_we_i    1 = write, 0 = read
//   cpu_addr_i  byte address
//   cpu_sel_i   byte-lane enables
//   cpu_data_i  write data
//   cpu_data_o  read data to core
//   stallreq_o  stall request to ctrl
//   err_o       one-cycle pulse on timeout abort
//   wb_*        Wishbone classic master signals
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no transfer; accepts a core request
// BUSY       | Wishbone cycle open, waiting for ack / flush / timeout
// WAIT_STALL | transfer done, pipeline stalled elsewhere; present rd_buf
module wb_bus_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic                wb_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  // count holds the number of BUSY cycles already completed without ack,
  // so the current cycle is the TIMEOUT-th one when count == TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rd_buf, rd_nxt;
  logic [DATA_W-1:0] rd_val;
  logic              timeout_hit;
  logic              accept;
  logic              bus_done;

  assign timeout_hit = (count == CNT_LAST);

  always_comb begin
    state_nxt  = state;
    rd_nxt     = rd_buf;
    rd_val     = '0;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    err_o      = 1'b0;
    accept     = 1'b0;
    bus_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          accept     = 1'b1;
          stallreq_o = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        stallreq_o = !wb_ack_i && !timeout_hit;
        if (flush_i) begin
          // flush wins over a simultaneous ack; the data is dropped
          bus_done  = 1'b1;
          state_nxt = IDLE;
        end else if (wb_ack_i) begin
          rd_val     = wb_we_o ? '0 : wb_dat_i;
          cpu_data_o = rd_val;
          rd_nxt     = rd_val;
          bus_done   = 1'b1;
          state_nxt  = (stall_i != 6'd0) ? WAIT_STALL : IDLE;
        end else if (timeout_hit) begin
          err_o     = 1'b1;
          rd_nxt    = '0;
          bus_done  = 1'b1;
          state_nxt = (stall_i != 6'd0) ? WAIT_STALL : IDLE;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (stall_i == 6'd0 || flush_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst_n) begin
      stallreq_o = 1'b0;
      cpu_data_o = '0;
      err_o      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      rd_buf   <= '0;
      count    <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_buf <= rd_nxt;
      if (accept) begin
        wb_adr_o <= cpu_addr_i;
        wb_dat_o <= cpu_data_i;
        wb_we_o  <= cpu_we_i;
        wb_sel_o <= cpu_sel_i;
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
        count    <= '0;
      end else if (bus_done) begin
        wb_adr_o <= '0;
        wb_dat_o <= '0;
        wb_we_o  <= 1'b0;
        wb_sel_o <= '0;
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
      end else if (state == BUSY) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_bus_if.sv
module tb_wb_bus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .err_o(err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, checks follow 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b1; cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0; cpu_sel_i = 4'hF; cpu_data_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
    tick(); tick(); #1;
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_cpu_data", cpu_data_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_adr", wb_adr_o, 0);

    // T1: read, ack on the 3rd BUSY cycle
    tick(); rst_n = 1'b0; cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80; #1;
    chk("t1_stall_idle", stallreq_o, 1);
    tick(); cpu_ce_i = 1'b0; #1;
    chk("t1_cyc", wb_cyc_o, 1);
    chk("t1_stb", wb_stb_o, 1);
    chk("t1_adr", wb_adr_o, 32'h80);
    chk("t1_we", wb_we_o, 0);
    chk("t1_stall_b1", stallreq_o, 1);
    tick(); #1;
    chk("t1_stall_b2", stallreq_o, 1);
    tick(); wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF; #1;
    chk("t1_stall_ack", stallreq_o, 0);
    chk("t1_data_ack", cpu_data_o, 32'hDEADBEEF);
    tick(); wb_ack_i = 1'b0; wb_dat_i = '0; #1;
    chk("t1_cyc_after", wb_cyc_o, 0);
    chk("t1_stb_after", wb_stb_o, 0);
    chk("t1_adr_after", wb_adr_o, 0);
    chk("t1_data_idle", cpu_data_o, 0);

    // T2: write with partial byte lanes
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h100; cpu_sel_i = 4'b0011;
    cpu_data_i = 32'h1234ABCD; #1;
    chk("t2_stall_idle", stallreq_o, 1);
    tick(); cpu_ce_i = 1'b0; #1;
    chk("t2_we", wb_we_o, 1);
    chk("t2_sel", wb_sel_o, 4'b0011);
    chk("t2_dat", wb_dat_o, 32'h1234ABCD);
    chk("t2_adr", wb_adr_o, 32'h100);
    tick(); wb_ack_i = 1'b1; wb_dat_i = 32'hFFFFFFFF; #1;
    chk("t2_we_held", wb_we_o, 1);
    chk("t2_data_write", cpu_data_o, 0);
    chk("t2_stall_ack", stallreq_o, 0);
    tick(); wb_ack_i = 1'b0; wb_dat_i = '0; #1;
    chk("t2_we_after", wb_we_o, 0);
    chk("t2_sel_after", wb_sel_o, 0);
    chk("t2_dat_after", wb_dat_o, 0);
    chk("t2_cyc_after", wb_cyc_o, 0);

    // T3: read acked while the pipeline is stalled elsewhere
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h200; cpu_sel_i = 4'hF;
    cpu_data_i = '0; #1;
    chk("t3_stall_idle", stallreq_o, 1);
    tick(); wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D; stall_i = 6'b000011;
    cpu_addr_i = 32'h300; #1;
    chk("t3_data_ack", cpu_data_o, 32'hCAFEF00D);
    tick(); wb_ack_i = 1'b0; wb_dat_i = '0; #1;
    chk("t3_ws1_data", cpu_data_o, 32'hCAFEF00D);
    chk("t3_ws1_stall", stallreq_o, 0);
    chk("t3_ws1_cyc", wb_cyc_o, 0);
    tick(); stall_i = '0; #1;
    chk("t3_ws2_data", cpu_data_o, 32'hCAFEF00D);
    chk("t3_ws2_stall", stallreq_o, 0);
    tick(); #1;
    chk("t3_idle_stall", stallreq_o, 1);
    chk("t3_idle_data", cpu_data_o, 0);
    tick(); cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h11112222; #1;
    chk("t3_adr2", wb_adr_o, 32'h300);
    chk("t3_data2", cpu_data_o, 32'h11112222);
    tick(); wb_ack_i = 1'b0; wb_dat_i = '0; #1;

    // T4: no ack, abort on the 4th BUSY cycle, then WAIT_STALL shows cleared rd_buf
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h400; #1;
    tick(); cpu_ce_i = 1'b0; #1;
    chk("t4_err_b1", err_o, 0);
    chk("t4_stall_b1", stallreq_o, 1);
    tick(); #1;
    chk("t4_err_b2", err_o, 0);
    tick(); #1;
    chk("t4_err_b3", err_o, 0);
    chk("t4_stall_b3", stallreq_o, 1);
    tick(); wb_dat_i = 32'hAAAA5555; stall_i = 6'b000001; #1;
    chk("t4_err_b4", err_o, 1);
    chk("t4_stall_b4", stallreq_o, 0);
    chk("t4_data_b4", cpu_data_o, 0);
    tick(); wb_dat_i = '0; #1;
    chk("t4_err_after", err_o, 0);
    chk("t4_cyc_after", wb_cyc_o, 0);
    chk("t4_rdbuf_cleared", cpu_data_o, 0);
    stall_i = '0;
    tick(); #1;

    // T4b: ack arrives on the timeout cycle; ack wins
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h440; #1;
    tick(); cpu_ce_i = 1'b0; #1;
    tick(); tick(); tick(); wb_ack_i = 1'b1; wb_dat_i = 32'h0BADF00D; #1;
    chk("t4b_err", err_o, 0);
    chk("t4b_data", cpu_data_o, 32'h0BADF00D);
    tick(); wb_ack_i = 1'b0; wb_dat_i = '0; #1;
    chk("t4b_cyc_after", wb_cyc_o, 0);

    // T5: flush in IDLE blocks the request; flush with ack discards data
    cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_addr_i = 32'h480; #1;
    chk("t5_flush_idle_stall", stallreq_o, 0);
    tick(); flush_i = 1'b0; cpu_ce_i = 1'b0; #1;
    chk("t5_flush_idle_cyc", wb_cyc_o, 0);
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h500; #1;
    tick(); cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h55AA55AA; flush_i = 1'b1;
    stall_i = 6'b000001; #1;
    chk("t5_flush_data", cpu_data_o, 0);
    chk("t5_flush_err", err_o, 0);
    tick(); wb_ack_i = 1'b0; wb_dat_i = '0; flush_i = 1'b0; #1;
    chk("t5_flush_idle_data", cpu_data_o, 0);
    chk("t5_flush_cyc", wb_cyc_o, 0);
    stall_i = '0;
    // reset in the middle of a BUSY cycle
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h600; #1;
    tick(); cpu_ce_i = 1'b0; #1;
    chk("t5_busy_cyc", wb_cyc_o, 1);
    rst_n = 1'b1; #1;
    chk("t5_rst_stall", stallreq_o, 0);
    tick(); rst_n = 1'b0; #1;
    chk("t5_rst_cyc", wb_cyc_o, 0);
    chk("t5_rst_stb", wb_stb_o, 0);
    chk("t5_rst_adr", wb_adr_o, 0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h77777777; #1;
    chk("t5_ack_idle_ignored", cpu_data_o, 0);
    chk("t5_ack_idle_stall", stallreq_o, 0);
    tick(); wb_ack_i = 1'b0; wb_dat_i = '0; #1;

    // T6: back-to-back reads against a zero-wait slave
    for (int i = 0; i < 3; i++) begin
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h1000 + 32'(4 * i); #1;
      chk("t6_stall_idle", stallreq_o, 1);
      tick(); wb_ack_i = 1'b1; wb_dat_i = 32'hA0 + 32'(i); #1;
      chk("t6_adr", wb_adr_o, 32'h1000 + 32'(4 * i));
      chk("t6_stall_ack", stallreq_o, 0);
      chk("t6_data", cpu_data_o, 32'hA0 + 32'(i));
      tick(); wb_ack_i = 1'b0; wb_dat_i = '0;
    end
    cpu_ce_i = 1'b0; #1;
    tick(); #1;
    chk("t6_cyc_end", wb_cyc_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
